rgb_ycbcr_binarizer: RTL and testbench
======================================

// Module: rgb_ycbcr_binarizer
// PURPOSE
//  Streaming video pixel pipeline: RGB888 in, YCbCr444 (BT.601 integer) out, plus a 1-bit
//  window-threshold mask on one selected channel (default Cb).
//  Sits between the camera/bitmap pixel source and downstream morphology/edge/display
//  stages; frame sync signals are delayed to stay aligned with the data.
// PARAMETERS
//  BIN_SEL   2'd1   channel binarized: 0=Y, 1=Cb, 2=Cr (3 treated as Cb)
//  BIN_LOW   8'd77  lower bound of white window, inclusive
//  BIN_HIGH  8'd127 upper bound of white window, inclusive
// PORTS
//  clk              in   1  pixel clock; all logic rising-edge
//  rst_n            in   1  asynchronous active-low reset
//  per_frame_vsync  in   1  input frame sync
//  per_frame_href   in   1  input line valid
//  per_frame_clken  in   1  input pixel enable; may toggle every other cycle within href
//  per_img_red      in   8  R
//  per_img_green    in   8  G
//  per_img_blue     in   8  B
//  post_frame_vsync out  1  per_frame_vsync delayed 4 cycles
//  post_frame_href  out  1  per_frame_href delayed 4 cycles
//  post_frame_clken out  1  per_frame_clken delayed 4 cycles
//  post_img_Y       out  8  luma, aligned with post_* syncs
//  post_img_Cb      out  8  blue-difference chroma, aligned
//  post_img_Cr      out  8  red-difference chroma, aligned
//  post_monoc       out  1  1 = white (selected channel inside [BIN_LOW,BIN_HIGH]), 0 = black
//  post_monoc_fall  out  1  one-cycle flag: mask transitioned white->black on this pixel
// BEHAVIOUR
//  - Reset: every register, including all outputs, is cleared to 0 asynchronously.
//  - Datapath runs every cycle, not gated by clken. Downstream qualifies pixels with
//    post_frame_href & post_frame_clken.
//  - Stage 1 (registered): nine 16-bit products:
//    77R, 150G, 29B, 43R, 85G, 128B, 128R, 107G, 21B.
//  - Stage 2 (registered), 16-bit unsigned; no under/overflow is possible for 8-bit inputs:
//    Ys  = 77R + 150G + 29B
//    Cbs = 128B + 32768 - 43R - 85G
//    Crs = 128R + 32768 - 107G - 21B
//  - Stage 3 (registered): Y/Cb/Cr = sum[15:8]. Truncate, no rounding, no clipping needed.
//  - Stage 4 (registered):
//    - Y/Cb/Cr delayed once more.
//    - monoc = (BIN_LOW <= sel && sel <= BIN_HIGH), where sel is the stage-3 channel.
//  - Total latency is 4 cycles for all outputs. Sync signals pass through a 4-deep shift
//    register.
//  - monoc_fall:
//    - prev_monoc is updated only on stage-3 cycles where href & clken are high, and is
//      cleared while href is low, so each line starts black.
//    - post_monoc_fall = valid & ~monoc_new & prev_monoc, registered alongside post_monoc.
//  - If BIN_LOW > BIN_HIGH the window is empty and post_monoc stays 0.
//  - Reset mid-frame: outputs clear immediately. After release, the first 4 cycles of
//    output carry zeros / pipeline fill.
//  - Back-to-back frames need no gaps. Any vsync/href pattern is simply delayed by 4.
// TESTING
//  1. Reset with pixels toggling -> all outputs 0 while rst_n=0; first valid data 4 clks
//     after release.
//  2. White (255,255,255) -> Y=255, Cb=128, Cr=128, monoc=0 (default window).
//     Black (0,0,0) -> Y=0, Cb=128, Cr=128, monoc=0.
//  3. Pure red (255,0,0) -> Y=76, Cb=85, Cr=255, monoc=1.
//     Pure green (0,255,0) -> Y=149, Cb=43, Cr=21, monoc=0.
//     Pure blue (0,0,255) -> Y=28, Cb=255, Cr=107, monoc=0.
//  4. Boundary: inputs giving Cb=76/77/127/128 -> monoc=0/1/1/0.
//     Sweep all BIN_SEL values with directed Y/Cr pixels.
//  5. Line red,red,black with clken alternating -> post_monoc_fall=1 only on the black
//     pixel's enabled cycle, 4 clks later; no fall on the first pixel of a new line.
//  6. Full 640x480 frame (clken every other clk, 15-clk blanking) -> exactly 307200
//     href&clken output pixels; vsync/href/clken match input delayed by exactly 4.

Source files
------------

// File: rtl/rgb_ycbcr_binarizer.sv
// RGB888 -> YCbCr444 (BT.601 integer) converter with a window-threshold mask on one
// channel; four-stage pipeline with frame syncs delayed to stay aligned with the data.
module rgb_ycbcr_binarizer #(
    parameter logic [1:0] BIN_SEL  = 2'd1,
    parameter logic [7:0] BIN_LOW  = 8'd77,
    parameter logic [7:0] BIN_HIGH = 8'd127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_red,
    input  logic [7:0] per_img_green,
    input  logic [7:0] per_img_blue,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img_Y,
    output logic [7:0] post_img_Cb,
    output logic [7:0] post_img_Cr,
    output logic       post_monoc,
    output logic       post_monoc_fall
);

    logic [15:0] p_ry, p_gy, p_by;
    logic [15:0] p_rb, p_gb, p_bb;
    logic [15:0] p_rr, p_gr, p_br;
    logic [15:0] y_sum, cb_sum, cr_sum;
    logic [7:0]  y3, cb3, cr3;
    logic [3:0]  vsync_sr, href_sr, clken_sr;
    logic        prev_monoc;
    logic [7:0]  sel3;
    logic        monoc_new;
    logic        valid3;

    // Stage 1: constant-coefficient products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_ry <= '0; p_gy <= '0; p_by <= '0;
            p_rb <= '0; p_gb <= '0; p_bb <= '0;
            p_rr <= '0; p_gr <= '0; p_br <= '0;
        end else begin
            p_ry <= {8'd0, per_img_red}   * 16'd77;
            p_gy <= {8'd0, per_img_green} * 16'd150;
            p_by <= {8'd0, per_img_blue}  * 16'd29;
            p_rb <= {8'd0, per_img_red}   * 16'd43;
            p_gb <= {8'd0, per_img_green} * 16'd85;
            p_bb <= {8'd0, per_img_blue}  * 16'd128;
            p_rr <= {8'd0, per_img_red}   * 16'd128;
            p_gr <= {8'd0, per_img_green} * 16'd107;
            p_br <= {8'd0, per_img_blue}  * 16'd21;
        end
    end

    // Stage 2: the +32768 offset keeps the chroma sums non-negative for any 8-bit input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_sum  <= '0;
            cb_sum <= '0;
            cr_sum <= '0;
        end else begin
            y_sum  <= p_ry + p_gy + p_by;
            cb_sum <= p_bb + 16'd32768 - p_rb - p_gb;
            cr_sum <= p_rr + 16'd32768 - p_gr - p_br;
        end
    end

    // Stage 3: truncate to the integer part
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y3  <= '0;
            cb3 <= '0;
            cr3 <= '0;
        end else begin
            y3  <= 8'(y_sum >> 8);
            cb3 <= 8'(cb_sum >> 8);
            cr3 <= 8'(cr_sum >> 8);
        end
    end

    always_comb begin
        sel3 = cb3;
        case (BIN_SEL)
            2'd0:    sel3 = y3;
            2'd2:    sel3 = cr3;
            default: sel3 = cb3;
        endcase
    end

    assign monoc_new = (sel3 >= BIN_LOW) && (sel3 <= BIN_HIGH);
    // Syncs are not a handshake: a pixel is valid when href & clken are both high.
    assign valid3    = href_sr[2] & clken_sr[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_sr <= '0;
            href_sr  <= '0;
            clken_sr <= '0;
        end else begin
            vsync_sr <= {vsync_sr[2:0], per_frame_vsync};
            href_sr  <= {href_sr[2:0],  per_frame_href};
            clken_sr <= {clken_sr[2:0], per_frame_clken};
        end
    end

    // Previous enabled pixel's mask on this line; cleared between lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_monoc <= 1'b0;
        end else if (!href_sr[2]) begin
            prev_monoc <= 1'b0;
        end else if (clken_sr[2]) begin
            prev_monoc <= monoc_new;
        end
    end

    // Stage 4: output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_Y      <= '0;
            post_img_Cb     <= '0;
            post_img_Cr     <= '0;
            post_monoc      <= 1'b0;
            post_monoc_fall <= 1'b0;
        end else begin
            post_img_Y      <= y3;
            post_img_Cb     <= cb3;
            post_img_Cr     <= cr3;
            post_monoc      <= monoc_new;
            post_monoc_fall <= valid3 & ~monoc_new & prev_monoc;
        end
    end

    assign post_frame_vsync = vsync_sr[3];
    assign post_frame_href  = href_sr[3];
    assign post_frame_clken = clken_sr[3];

endmodule

// File: tb/tb_rgb_ycbcr_binarizer.sv
// Bench for rgb_ycbcr_binarizer: five instances (channel/window variants) share one
// stimulus stream and are compared every cycle against an arithmetic reference model.
module tb_rgb_ycbcr_binarizer;

    localparam int N = 5;
    // Instances: 0 default (Cb), 1 Y, 2 Cr, 3 sel=3 (acts as Cb), 4 empty window
    localparam logic [2*N-1:0] SEL_T  = {2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
    localparam logic [8*N-1:0] LOW_T  = {8'd200, 8'd77, 8'd77, 8'd77, 8'd77};
    localparam logic [8*N-1:0] HIGH_T = {8'd100, 8'd127, 8'd127, 8'd127, 8'd127};
    localparam int FW = 64;
    localparam int FH = 48;

    typedef struct packed {
        logic [2:0]   sync;
        logic [23:0]  ycc;
        logic [N-1:0] mono;
        logic [N-1:0] fall;
        logic         dchk;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;

    logic [N-1:0] o_vs, o_hs, o_ce, o_m, o_f;
    logic [7:0]   o_y[N];
    logic [7:0]   o_cb[N];
    logic [7:0]   o_cr[N];

    ent_t         exp_q[$];
    logic [N-1:0] prev_m = '0;
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int pix_cnt = 0;
    int fall_cnt = 0;
    int last_fall_cyc = -1;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        rgb_ycbcr_binarizer #(
            .BIN_SEL (SEL_T[2*gi +: 2]),
            .BIN_LOW (LOW_T[8*gi +: 8]),
            .BIN_HIGH(HIGH_T[8*gi +: 8])
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .per_frame_vsync (vsync),
            .per_frame_href  (href),
            .per_frame_clken (clken),
            .per_img_red     (r),
            .per_img_green   (g),
            .per_img_blue    (b),
            .post_frame_vsync(o_vs[gi]),
            .post_frame_href (o_hs[gi]),
            .post_frame_clken(o_ce[gi]),
            .post_img_Y      (o_y[gi]),
            .post_img_Cb     (o_cb[gi]),
            .post_img_Cr     (o_cr[gi]),
            .post_monoc      (o_m[gi]),
            .post_monoc_fall (o_f[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // BT.601 integer conversion straight from the defining sums
    function automatic logic [23:0] ref_ycc(input logic [7:0] rr, input logic [7:0] gg,
                                            input logic [7:0] bb);
        int ri, gv, bi, y, cb, cr;
        ri = int'(rr); gv = int'(gg); bi = int'(bb);
        y  = (77 * ri + 150 * gv + 29 * bi) / 256;
        cb = (128 * bi - 43 * ri - 85 * gv + 32768) / 256;
        cr = (128 * ri - 107 * gv - 21 * bi + 32768) / 256;
        return {8'(y), 8'(cb), 8'(cr)};
    endfunction

    function automatic logic ref_win(input int i, input logic [23:0] ycc);
        logic [1:0] sel;
        logic [7:0] ch, lo, hi;
        sel = SEL_T[2*i +: 2];
        lo  = LOW_T[8*i +: 8];
        hi  = HIGH_T[8*i +: 8];
        ch  = (sel == 2'd0) ? ycc[23:16] : (sel == 2'd2) ? ycc[7:0] : ycc[15:8];
        return (ch >= lo) && (ch <= hi);
    endfunction

    function automatic ent_t zero_ent();
        return '0;
    endfunction

    // One clock: model consumes the sampled inputs, then outputs are compared after the edge
    task automatic step();
        ent_t e, x;
        @(posedge clk);
        e = '0;
        if (rst_n) begin
            e.sync = {vsync, href, clken};
            e.ycc  = ref_ycc(r, g, b);
            for (int i = 0; i < N; i++) begin
                e.mono[i] = ref_win(i, e.ycc);
                e.fall[i] = href & clken & prev_m[i] & ~e.mono[i];
            end
            if (!href) prev_m = '0;
            else if (clken) prev_m = e.mono;
            e.dchk = 1'b1;
        end
        exp_q.push_back(e);
        x = exp_q.pop_front();
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("sync[%0d]", i), {29'd0, o_vs[i], o_hs[i], o_ce[i]}, {29'd0, x.sync});
            if (!rst_n) begin
                check_eq($sformatf("rst_data[%0d]", i),
                         {6'd0, o_y[i], o_cb[i], o_cr[i], o_m[i], o_f[i]}, 32'd0);
            end else if (x.dchk) begin
                check_eq($sformatf("ycc[%0d]", i), {8'd0, o_y[i], o_cb[i], o_cr[i]}, {8'd0, x.ycc});
                check_eq($sformatf("monoc[%0d]", i), {31'd0, o_m[i]}, {31'd0, x.mono[i]});
                check_eq($sformatf("fall[%0d]", i), {31'd0, o_f[i]}, {31'd0, x.fall[i]});
            end
        end
        if (o_hs[0] & o_ce[0]) pix_cnt++;
        if (o_f[0]) begin
            fall_cnt++;
            last_fall_cyc = cyc;
        end
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        prev_m = '0;
        exp_q.delete();
        repeat (3) exp_q.push_back(zero_ent());
        #1;
        check_eq("async_clear", {4'd0, o_vs, o_hs, o_ce, o_m, o_f, 3'd0},
                 32'd0);
        for (int k = 0; k < n; k++) begin
            href = ~href;
            clken = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            step();
        end
        rst_n = 1'b1;
    endtask

    task automatic hold_px(input string tag, input logic [7:0] rr, input logic [7:0] gg,
                           input logic [7:0] bb, input logic [7:0] ey, input logic [7:0] ecb,
                           input logic [7:0] ecr, input logic [N-1:0] em);
        vsync = 1'b0; href = 1'b1; clken = 1'b1;
        r = rr; g = gg; b = bb;
        repeat (4) step();
        check_eq({tag, "_ycc"}, {8'd0, o_y[0], o_cb[0], o_cr[0]}, {8'd0, ey, ecb, ecr});
        check_eq({tag, "_monoc"}, {27'd0, o_m}, {27'd0, em});
    endtask

    task automatic idle(input int n);
        href = 1'b0; clken = 1'b0; vsync = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int black_cyc;
        repeat (3) exp_q.push_back(zero_ent());

        // Reset with pixels toggling, then first valid data after 4 clocks
        apply_reset(6);
        vsync = 1'b0; href = 1'b1; clken = 1'b1;
        r = 8'd255; g = 8'd255; b = 8'd255;
        repeat (3) step();
        check_eq("fill_href", {31'd0, o_hs[0]}, 32'd0);
        step();
        check_eq("first_href", {31'd0, o_hs[0]}, 32'd1);
        check_eq("first_y", {24'd0, o_y[0]}, 32'd255);

        // Directed colours; monoc vector bit i belongs to instance i
        hold_px("white", 8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128, 5'b00000);
        hold_px("black", 8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128, 5'b00000);
        hold_px("red",   8'd255, 8'd0,   8'd0,   8'd76,  8'd85,  8'd255, 5'b01001);
        hold_px("green", 8'd0,   8'd255, 8'd0,   8'd149, 8'd43,  8'd21,  5'b00000);
        hold_px("blue",  8'd0,   8'd0,   8'd255, 8'd28,  8'd255, 8'd107, 5'b00100);
        hold_px("gray",  8'd100, 8'd100, 8'd100, 8'd100, 8'd128, 8'd128, 5'b00010);
        // Window edges on Cb: 76 / 77 / 127 / 128
        hold_px("cb76",  8'd0, 8'd154, 8'd0, 8'd90, 8'd76,  8'd63,  5'b00010);
        hold_px("cb77",  8'd0, 8'd151, 8'd0, 8'd88, 8'd77,  8'd64,  5'b01011);
        hold_px("cb127", 8'd0, 8'd1,   8'd0, 8'd0,  8'd127, 8'd127, 5'b01101);
        hold_px("cb128", 8'd0, 8'd0,   8'd0, 8'd0,  8'd128, 8'd128, 5'b00000);

        // Line red,red,black with clken alternating: one fall, on the black pixel
        idle(8);
        fall_cnt = 0;
        black_cyc = 0;
        href = 1'b1;
        for (int k = 0; k < 6; k++) begin
            clken = (k % 2 == 0);
            {r, g, b} = (k < 4) ? 24'hff0000 : 24'h000000;
            step();
            if (k == 4) black_cyc = cyc;
        end
        idle(8);
        check_eq("fall_count", 32'(fall_cnt), 32'd1);
        check_eq("fall_cycle", 32'(last_fall_cyc), 32'(black_cyc + 3));

        // White-ended line followed by a line starting black: no fall
        fall_cnt = 0;
        href = 1'b1; clken = 1'b1; {r, g, b} = 24'hff0000;
        step();
        idle(3);
        href = 1'b1; clken = 1'b1; {r, g, b} = 24'h000000;
        repeat (2) step();
        idle(6);
        check_eq("new_line_no_fall", 32'(fall_cnt), 32'd0);

        // Randomized traffic with a reset in the middle
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) href = ~href;
            if ($urandom_range(0, 31) == 0) vsync = ~vsync;
            clken = 1'($urandom_range(0, 1));
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            if ($urandom_range(0, 3) == 0) {r, g, b} = 24'hff0000;
            step();
            if (k == 1500) apply_reset(3);
        end

        // Scaled frame: clken every other clock, 15-clock horizontal blanking
        idle(4);
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (5) step();
        pix_cnt = 0;
        for (int ln = 0; ln < FH; ln++) begin
            href = 1'b1;
            for (int px = 0; px < 2 * FW; px++) begin
                clken = (px % 2 == 0);
                if (clken) begin
                    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                end
                step();
            end
            href = 1'b0; clken = 1'b0;
            repeat (15) step();
        end
        idle(6);
        check_eq("frame_pixels", 32'(pix_cnt), 32'(FW * FH));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
